// File: rtl/aes128_pkg.sv
// Shared definitions for the AES128 stream front-end.
// Holds the block/word geometry, the controller state encoding, the word
// index type and the helper that sizes the wait counter from the timing
// parameters.
package aes128_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_DROP,
    ST_KEYGEN,
    ST_ROUND,
    ST_OUT,
    ST_EMIT
  } state_t;

  typedef logic [1:0] word_idx_t;

  // The wait counter width depends on the instance parameters, so the
  // counter type itself is declared in the controller using this width.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/aes128_word_packer.sv
// Shift-in assembler turning a 32-bit word stream into 128-bit groups.
// Ports:
//   clk, resetn      clock, async active-high reset
//   accept           a word is transferred this cycle
//   is_key, data     type tag and payload of the transferred word
//   complete         pulse: this transfer is the 4th word of a same-type group
//   complete_is_key  type of the group that completes
//   block            assembled group, first word in [127:96]; valid with complete
module aes128_word_packer
  import aes128_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   accept,
  input  logic                   is_key,
  input  logic [WORD_W-1:0]      data,
  output logic                   complete,
  output logic                   complete_is_key,
  output logic [AES_BLOCK_W-1:0] block
);

  logic [3*WORD_W-1:0] shreg;
  word_idx_t           count;
  logic                tag;
  logic                restart;

  // A word of the other type throws away the partial group and starts anew.
  assign restart         = (count == '0) || (tag != is_key);
  assign complete        = accept && !restart && (count == word_idx_t'(WORDS_PER_BLOCK - 1));
  assign complete_is_key = tag;
  // Stale words left by a discarded group are shifted out before completion.
  assign block           = {shreg, data};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      shreg <= '0;
      count <= '0;
      tag   <= 1'b0;
    end else if (accept) begin
      shreg <= {shreg[2*WORD_W-1:0], data};
      if (restart) begin
        tag   <= is_key;
        count <= word_idx_t'(1);
      end else begin
        count <= count + word_idx_t'(1);
      end
    end
  end

endmodule

// File: rtl/aes128_stream_ctrl.sv
// Stream front-end and output drain for the AES128 core.
// Ports:
//   clk, resetn                 clock, async active-high reset
//   s_valid/s_ready/s_data/s_is_key   32-bit key/plaintext word input stream
//   m_valid/m_ready/m_data/m_last     32-bit ciphertext output stream
//   aes_in_key, aes_in_data     block operands to the core
//   aes_valid_key_gen/round/out core sequencing controls
//   aes_out_data                ciphertext from the core
//   key_loaded                  key expansion wait finished
//   err_nokey                   sticky: plaintext block arrived without a key
//
// state    | meaning
// IDLE     | accepting words into the packer
// KEY_DROP | one cycle with valid_key_gen low so the core restarts expansion
// KEYGEN   | valid_key_gen held for KEYGEN_CYCLES
// ROUND    | valid_round held for ROUND_CYCLES
// OUT      | valid_round and valid_out held for OUT_WAIT, capture on last
// EMIT     | serialise the captured ciphertext, 4 words
module aes128_stream_ctrl
  import aes128_pkg::*;
#(
  parameter int KEYGEN_CYCLES = 11,
  parameter int ROUND_CYCLES  = 11,
  parameter int OUT_WAIT      = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WORD_W-1:0]      s_data,
  input  logic                   s_is_key,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WORD_W-1:0]      m_data,
  output logic                   m_last,
  output logic [AES_BLOCK_W-1:0] aes_in_key,
  output logic [AES_BLOCK_W-1:0] aes_in_data,
  output logic                   aes_valid_key_gen,
  output logic                   aes_valid_round,
  output logic                   aes_valid_out,
  input  logic [AES_BLOCK_W-1:0] aes_out_data,
  output logic                   key_loaded,
  output logic                   err_nokey
);

  localparam int CNT_W = cnt_width(KEYGEN_CYCLES, ROUND_CYCLES, OUT_WAIT);
  typedef logic [CNT_W-1:0] cnt_t;

  // Down-counters are loaded with N-1 and end at zero, so N=1 gives one cycle.
  localparam cnt_t KEYGEN_LOAD = cnt_t'(KEYGEN_CYCLES - 1);
  localparam cnt_t ROUND_LOAD  = cnt_t'(ROUND_CYCLES - 1);
  localparam cnt_t OUT_LOAD    = cnt_t'(OUT_WAIT - 1);

  state_t    state, state_next;
  cnt_t      cnt, cnt_next;
  word_idx_t idx, idx_next;
  logic      load_key, load_data, set_err, key_done, capture;

  logic                   pk_complete, pk_is_key;
  logic [AES_BLOCK_W-1:0] pk_block;
  logic [WORD_W-1:0]      cap_words [WORDS_PER_BLOCK];

  // Reset gates s_ready so every output reads 0 while reset is held.
  assign s_ready = (state == ST_IDLE) && !resetn;

  aes128_word_packer u_packer (
    .clk             (clk),
    .resetn          (resetn),
    .accept          (s_valid && s_ready),
    .is_key          (s_is_key),
    .data            (s_data),
    .complete        (pk_complete),
    .complete_is_key (pk_is_key),
    .block           (pk_block)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    load_key   = 1'b0;
    load_data  = 1'b0;
    set_err    = 1'b0;
    key_done   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pk_complete) begin
          if (pk_is_key) begin
            load_key   = 1'b1;
            state_next = ST_KEY_DROP;
          end else if (key_loaded) begin
            load_data  = 1'b1;
            cnt_next   = ROUND_LOAD;
            state_next = ST_ROUND;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_KEY_DROP: begin
        cnt_next   = KEYGEN_LOAD;
        state_next = ST_KEYGEN;
      end
      ST_KEYGEN: begin
        if (cnt == '0) begin
          key_done   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
      ST_ROUND: begin
        if (cnt == '0) begin
          cnt_next   = OUT_LOAD;
          state_next = ST_OUT;
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
      ST_OUT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = ST_EMIT;
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
      ST_EMIT: begin
        if (m_ready) begin
          if (idx == word_idx_t'(WORDS_PER_BLOCK - 1)) state_next = ST_IDLE;
          else                                         idx_next   = idx + word_idx_t'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      aes_in_key  <= '0;
      aes_in_data <= '0;
      key_loaded  <= 1'b0;
      err_nokey   <= 1'b0;
      cap_words   <= '{default: '0};
    end else begin
      if (load_key) begin
        aes_in_key <= pk_block;
        key_loaded <= 1'b0;
      end
      if (key_done)  key_loaded  <= 1'b1;
      if (load_data) aes_in_data <= pk_block;
      if (set_err)   err_nokey   <= 1'b1;
      if (capture) begin
        for (int i = 0; i < WORDS_PER_BLOCK; i++)
          cap_words[i] <= aes_out_data[AES_BLOCK_W-1-WORD_W*i -: WORD_W];
      end
    end
  end

  // The core keeps its expanded key only while valid_key_gen stays high.
  assign aes_valid_key_gen = (state == ST_KEYGEN) || key_loaded;
  assign aes_valid_round   = (state == ST_ROUND) || (state == ST_OUT);
  assign aes_valid_out     = (state == ST_OUT);
  assign m_valid           = (state == ST_EMIT);
  assign m_last            = (state == ST_EMIT) && (idx == word_idx_t'(WORDS_PER_BLOCK - 1));
  assign m_data            = cap_words[idx];

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// Bench for aes128_stream_ctrl. A behavioural AES-128 stands in for the core
// and also produces the expected ciphertext from the bench's own key/plaintext.
module tb_aes128_stream_ctrl;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_is_key = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         m_last;
  logic [127:0] aes_in_key, aes_in_data, aes_out_data;
  logic         aes_valid_key_gen, aes_valid_round, aes_valid_out;
  logic         key_loaded, err_nokey;

  int checks = 0;
  int failures = 0;

  logic [127:0] mkey;
  bit           mkey_ok = 0;

  always #5 clk = ~clk;

  aes128_stream_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_is_key          (s_is_key),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .aes_in_key        (aes_in_key),
    .aes_in_data       (aes_in_data),
    .aes_valid_key_gen (aes_valid_key_gen),
    .aes_valid_round   (aes_valid_round),
    .aes_valid_out     (aes_valid_out),
    .aes_out_data      (aes_out_data),
    .key_loaded        (key_loaded),
    .err_nokey         (err_nokey)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, b;
    inv = 8'h01; b = x;
    for (int i = 1; i < 8; i++) begin
      b = gmul(b, b);
      inv = gmul(inv, b);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core model: ciphertext is only presented while valid_out is high.
  always_comb aes_out_data = aes_valid_out ? aes_enc(aes_in_key, aes_in_data) : '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic k);
    s_valid = 1'b1; s_data = d; s_is_key = k;
    for (int n = 0; n < 200; n++) begin
      if (s_ready) begin
        tick();
        s_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("s_ready_timeout", s_ready, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_group(input logic [127:0] blk, input logic k);
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], k);
  endtask

  task automatic load_key(input logic [127:0] k);
    int  n;
    bit  vkg_bad;
    send_group(k, 1'b1);
    mkey = k; mkey_ok = 0;
    chk("in_key", aes_in_key, k);
    chk("drop_vkg", aes_valid_key_gen, 0);
    chk("drop_key_loaded", key_loaded, 0);
    tick();
    n = 0; vkg_bad = 0;
    while (!key_loaded && n < 100) begin
      if (!aes_valid_key_gen || s_ready) vkg_bad = 1;
      n++;
      tick();
    end
    chk("keygen_cycles", n, 11);
    chk("keygen_vkg_held", vkg_bad, 0);
    chk("key_loaded_vkg", {key_loaded, aes_valid_key_gen, s_ready}, 3'b111);
    mkey_ok = 1;
  endtask

  // mode 0: m_ready always 1; 1: toggling 1/0; 2: random
  task automatic encrypt(input logic [127:0] pt, input int mode, output logic [127:0] got);
    logic [127:0] exp;
    int  lat, vr_n, vo_n, w, k;
    bit  sr_bad, mv_seen, rdy;
    got = '0;
    send_group(pt, 1'b0);
    if (!mkey_ok) begin
      chk("nokey_err", err_nokey, 1);
      mv_seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (m_valid || aes_valid_round) mv_seen = 1;
        tick();
      end
      chk("nokey_no_output", mv_seen, 0);
      chk("nokey_s_ready", s_ready, 1);
      return;
    end
    exp = aes_enc(mkey, pt);
    chk("in_data", aes_in_data, pt);
    chk("vkg_during_round", aes_valid_key_gen, 1);
    lat = 0; vr_n = 0; vo_n = 0; sr_bad = 0;
    while (!m_valid && lat < 100) begin
      if (s_ready) sr_bad = 1;
      if (aes_valid_round) vr_n++;
      if (aes_valid_out) vo_n++;
      lat++;
      tick();
    end
    chk("latency", lat, 12);
    chk("valid_round_cycles", vr_n, 12);
    chk("valid_out_cycles", vo_n, 1);
    chk("emit_ctrl_low", {aes_valid_round, aes_valid_out}, 2'b00);
    w = 0; k = 0;
    while (w < 4 && k < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (k % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      chk("m_valid", m_valid, 1);
      chk("m_data", m_data, exp[127-32*w -: 32]);
      chk("m_last", m_last, (w == 3));
      if (s_ready) sr_bad = 1;
      got[127-32*w -: 32] = m_data;
      tick();
      if (rdy) w++;
      k++;
    end
    m_ready = 1'b0;
    chk("emit_words", w, 4);
    chk("after_emit", {m_valid, s_ready}, 2'b01);
    chk("s_ready_busy", sr_bad, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {s_ready, m_valid, m_last, aes_valid_key_gen, aes_valid_round,
                         aes_valid_out, key_loaded, err_nokey}, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_in_key"}, aes_in_key, 0);
    chk({tag, "_in_data"}, aes_in_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] got, got_a, pt_rand, kb;
    int n_part;
    bit ptype;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    resetn = 1'b0;
    tick();
    chk("s_ready_after_reset", s_ready, 1);

    // Partial key discarded by a data word; data group without a key
    send_word(32'hdead0001, 1'b1);
    send_word(32'hdead0002, 1'b1);
    encrypt(128'h00112233445566778899aabbccddeeff, 0, got);
    chk("partial_key_in_key", aes_in_key, 0);
    chk("partial_key_loaded", key_loaded, 0);

    resetn = 1'b1; #1;
    chk("err_cleared", err_nokey, 0);
    tick();
    resetn = 1'b0;
    tick();

    // FIPS-197 vector
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    encrypt(128'h00112233445566778899aabbccddeeff, 0, got);
    chk("fips_ct", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Backpressure with toggling m_ready
    load_key(128'h0123456789abcdef0123456789abcdef);
    encrypt(128'hd7e5dbd3324595f8fdc7d7c571da6c2a, 1, got_a);

    // Key change, same plaintext
    kb = {$urandom, $urandom, $urandom, $urandom};
    load_key(kb);
    encrypt(128'hd7e5dbd3324595f8fdc7d7c571da6c2a, 2, got);
    chk("key_b_differs", (got != got_a), 1);

    // Reset during ROUND
    send_group(128'h00112233445566778899aabbccddeeff, 1'b0);
    tick(); tick(); tick();
    chk("in_round", aes_valid_round, 1);
    resetn = 1'b1; #1;
    check_all_zero("mid_reset");
    tick();
    resetn = 1'b0;
    mkey_ok = 0;
    tick();
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    encrypt(128'h00112233445566778899aabbccddeeff, 2, got);
    chk("post_reset_ct", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Randomised mix of key loads, plaintext blocks and discarded partials
    for (int it = 0; it < 10; it++) begin
      ptype = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        n_part = $urandom_range(1, 3);
        for (int j = 0; j < n_part; j++) send_word($urandom, !ptype);
      end
      if (ptype) begin
        load_key({$urandom, $urandom, $urandom, $urandom});
      end else begin
        pt_rand = {$urandom, $urandom, $urandom, $urandom};
        encrypt(pt_rand, int'($urandom_range(0, 2)), got);
      end
    end
    chk("final_err_nokey", err_nokey, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
